xge_wb_master: RTL

XGE_WB_MASTER -- requirements
Module: xge_wb_master

---
 rtl/xge_wb_master_if.sv | 33 +++
 rtl/xge_wb_master.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/xge_wb_master_if.sv
// Command/response and Wishbone signal bundle for xge_wb_master.
// cmd_val/cmd_rdy: a command transfers on an edge where both are high; rsp_val is a one-cycle strobe with no back-pressure.
interface xge_wb_master_if;
  logic        cmd_val;
  logic        cmd_rdy;
  logic        cmd_we;
  logic [7:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_val;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_irq;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_int_i;

  modport master (
    input  cmd_val, cmd_we, cmd_adr, cmd_dat, wb_dat_i, wb_ack_i, wb_int_i,
    output cmd_rdy, rsp_val, rsp_dat, rsp_err, rsp_irq,
           wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output cmd_val, cmd_we, cmd_adr, cmd_dat, wb_dat_i, wb_ack_i, wb_int_i,
    input  cmd_rdy, rsp_val, rsp_dat, rsp_err, rsp_irq,
           wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/xge_wb_master.sv
// Single-outstanding Wishbone register master with ack timeout.
// Define XGE_WB_MASTER_IRQ_READ_EN to auto-read IRQ_ADR on a rising wb_int_i.
module xge_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  IRQ_ADR        = 8'h08
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  xge_wb_master_if.master bus,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        rdy_q, rdy_d;
  logic        rsp_val_q, rsp_val_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        irq_req;
  logic        pend_next;

`ifdef XGE_WB_MASTER_IRQ_READ_EN
  logic int_q, int_d;
  logic pend_q, pend_d;
  logic irq_txn_q, irq_txn_d;
  logic rsp_irq_q, rsp_irq_d;
  logic int_rise;

  assign int_rise  = bus.wb_int_i & ~int_q;
  assign int_d     = bus.wb_int_i;
  assign irq_req   = pend_q;
  assign pend_next = pend_d;
  assign bus.rsp_irq = rsp_irq_q;
`else
  wire [8:0] unused_irq = {bus.wb_int_i, IRQ_ADR};
  assign irq_req   = 1'b0;
  assign pend_next = 1'b0;
  assign bus.rsp_irq = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    rsp_val_d = 1'b0;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
`ifdef XGE_WB_MASTER_IRQ_READ_EN
    pend_d    = pend_q;
    irq_txn_d = irq_txn_q;
    rsp_irq_d = rsp_irq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A pending interrupt read outranks any user command.
        if (irq_req) begin
          adr_d   = IRQ_ADR;
          dat_d   = '0;
          we_d    = 1'b0;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
`ifdef XGE_WB_MASTER_IRQ_READ_EN
          pend_d    = 1'b0;
          irq_txn_d = 1'b1;
`endif
        end else if (bus.cmd_val && rdy_q) begin
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          we_d    = bus.cmd_we;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
`ifdef XGE_WB_MASTER_IRQ_READ_EN
          irq_txn_d = 1'b0;
`endif
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.wb_ack_i) begin
          rsp_dat_d = we_q ? 32'h0 : bus.wb_dat_i;
          rsp_err_d = 1'b0;
          rsp_val_d = 1'b1;
          cyc_d     = 1'b0;
          state_d   = ST_DONE;
`ifdef XGE_WB_MASTER_IRQ_READ_EN
          rsp_irq_d = irq_txn_q;
`endif
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          rsp_val_d = 1'b1;
          cyc_d     = 1'b0;
          state_d   = ST_DONE;
`ifdef XGE_WB_MASTER_IRQ_READ_EN
          rsp_irq_d = irq_txn_q;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef XGE_WB_MASTER_IRQ_READ_EN
    // New edges merge into the flag, including during an in-flight IRQ read.
    if (int_rise) pend_d = 1'b1;
`endif
    rdy_d = (state_d == ST_IDLE) && !pend_next;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      rsp_val_q <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef XGE_WB_MASTER_IRQ_READ_EN
      int_q     <= 1'b0;
      pend_q    <= 1'b0;
      irq_txn_q <= 1'b0;
      rsp_irq_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      rdy_q     <= rdy_d;
      rsp_val_q <= rsp_val_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
`ifdef XGE_WB_MASTER_IRQ_READ_EN
      int_q     <= int_d;
      pend_q    <= pend_d;
      irq_txn_q <= irq_txn_d;
      rsp_irq_q <= rsp_irq_d;
`endif
    end
  end

  assign bus.cmd_rdy  = rdy_q;
  assign bus.rsp_val  = rsp_val_q;
  assign bus.rsp_dat  = rsp_dat_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign dbg_state    = state_q;

endmodule
